fft_frame_sched: RTL and testbench

- Frame scheduler for the R2 pipelined FFT back end.
- Counts enabled pipeline cycles, waits out pipeline latency, and drives ping-pong writes of natural-order FFT results into two output buffer banks (re/im RAM pairs).
- Independently scans the oldest full bank in bit-reversed address order and hands samples to a downstream consumer over a valid/ready handshake.
- Replaces free-running reorder control with explicit bank ownership, frame-drop signalling and optional output pacing.

---
 rtl/fft_frame_sched.sv | 167 ++++++++++++++++
 tb/tb_fft_frame_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// Frame scheduler for the R2 pipelined FFT back end: ping-pong output banks, bit-reversed scan.
// Optional output pacing (per-index display hold) is enabled by defining FFT_SCHED_PACE_EN.
`timescale 1ns/1ps
module fft_frame_sched #(
  parameter int          WIDTH = 16,
  parameter int          N     = 9,
  parameter logic [15:0] LAT   = 16'd9,
  parameter logic [23:0] HOLD  = 24'd400000
) (
  input  logic                    clk,
  input  logic                    areset,
  input  logic                    din_valid,
  output logic                    fft_en,
  output logic                    wr_en,
  output logic                    wr_bank,
  output logic [N-1:0]            wr_addr,
  output logic                    rd_bank,
  output logic [N-1:0]            rd_addr,
  input  logic signed [WIDTH-1:0] rd_re,
  input  logic signed [WIDTH-1:0] rd_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_idx,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic [1:0]              bank_full,
  output logic                    frame_drop,
  output logic                    frame_done
);

  localparam logic [N-1:0] LAST = '1;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_VALID} rd_state_t;

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = a[N-1-i];
    return r;
  endfunction

  logic [15:0]  lat_cnt;
  logic         primed;
  logic         fire;
  logic [N-1:0] wc;
  logic         keep_r;
  logic         frame_start;
  logic         bank_free;
  logic         frame_keep;
  logic         wr_set;
  logic         wbank_r;
  logic [1:0]   full_r;
  logic [1:0]   full_nxt;

  rd_state_t    state, state_nxt;
  logic [N-1:0] ri, ri_nxt;
  logic         rbank, rbank_nxt;
  logic         rd_clr;

  // Writer: priming, frame admission and bank filling
  assign primed      = (lat_cnt == LAT);
  assign fire        = din_valid & primed & ~areset;
  assign frame_start = fire & (wc == '0);
  // A bank released by the reader in this very cycle is already free for the new frame.
  assign bank_free   = ~full_r[wbank_r] | (rd_clr & (rbank == wbank_r));
  assign frame_keep  = frame_start ? bank_free : keep_r;
  assign wr_set      = wr_en & (wc == LAST);

  assign fft_en     = din_valid;
  assign wr_en      = fire & frame_keep;
  assign wr_addr    = wc;
  assign wr_bank    = wbank_r;
  assign frame_drop = frame_start & ~bank_free;

  always_comb begin
    full_nxt = full_r;
    if (rd_clr) full_nxt[rbank] = 1'b0;
    if (wr_set) full_nxt[wbank_r] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      lat_cnt <= '0;
      wc      <= '0;
      keep_r  <= 1'b0;
      wbank_r <= 1'b0;
      full_r  <= '0;
    end else begin
      if (din_valid && !primed) lat_cnt <= lat_cnt + 16'd1;
      if (fire) wc <= wc + 1'b1;
      if (frame_start) keep_r <= bank_free;
      if (wr_set) wbank_r <= ~wbank_r;
      full_r <= full_nxt;
    end
  end

  // Reader: bank selection and bit-reversed scan with valid/ready handoff
`ifdef FFT_SCHED_PACE_EN
  logic [23:0] hcnt;

  always_ff @(posedge clk) begin
    if (areset) begin
      hcnt <= '0;
    end else if (state == R_ADDR) begin
      hcnt <= '0;
    end else if (state == R_VALID && hcnt != HOLD) begin
      hcnt <= hcnt + 24'd1;
    end
  end

  assign out_valid = (state == R_VALID) && (hcnt == HOLD);
`else
  logic [23:0] unused_hold;
  assign unused_hold = HOLD;
  assign out_valid   = (state == R_VALID);
`endif

  assign rd_clr = out_valid & out_ready & (ri == LAST) & ~areset;

  always_comb begin
    state_nxt = state;
    ri_nxt    = ri;
    rbank_nxt = rbank;
    case (state)
      R_IDLE: begin
        if (|full_r) begin
          // Exactly one full: take it. Both full: the bank the writer is not targeting.
          rbank_nxt = (&full_r) ? ~wbank_r : full_r[1];
          ri_nxt    = '0;
          state_nxt = R_ADDR;
        end
      end
      R_ADDR: state_nxt = R_VALID;
      R_VALID: begin
        if (out_valid && out_ready) begin
          if (ri == LAST) begin
            state_nxt = R_IDLE;
          end else begin
            ri_nxt    = ri + 1'b1;
            state_nxt = R_ADDR;
          end
        end
      end
      default: state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state <= R_IDLE;
      ri    <= '0;
      rbank <= 1'b0;
    end else begin
      state <= state_nxt;
      ri    <= ri_nxt;
      rbank <= rbank_nxt;
    end
  end

  assign rd_bank    = rbank;
  assign rd_addr    = bitrev(ri);
  assign out_idx    = ri;
  assign out_re     = (state == R_VALID) ? rd_re : '0;
  assign out_im     = (state == R_VALID) ? rd_im : '0;
  assign bank_full  = full_r;
  assign frame_done = rd_clr;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Directed bench for fft_frame_sched with a two-bank RAM model (re = natural index, im = frame serial).
`timescale 1ns/1ps
module tb_fft_frame_sched;
  localparam int WIDTH = 16;
  localparam int N     = 9;
`ifdef FFT_SCHED_PACE_EN
  localparam int EXP_GAP = 5;
`else
  localparam int EXP_GAP = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    areset, din_valid, out_ready;
  logic                    fft_en, wr_en, wr_bank, rd_bank, out_valid, frame_drop, frame_done;
  logic [N-1:0]            wr_addr, rd_addr, out_idx;
  logic signed [WIDTH-1:0] rd_re, rd_im, out_re, out_im;
  logic [1:0]              bank_full;

  fft_frame_sched #(.WIDTH(WIDTH), .N(N), .LAT(16'd9), .HOLD(24'd4)) dut (
    .clk(clk), .areset(areset), .din_valid(din_valid), .fft_en(fft_en),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_re(rd_re), .rd_im(rd_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_re(out_re), .out_im(out_im), .bank_full(bank_full),
    .frame_drop(frame_drop), .frame_done(frame_done)
  );

  logic signed [WIDTH-1:0] mem_re [2][512];
  logic signed [WIDTH-1:0] mem_im [2][512];
  logic [15:0] serial_q = 16'd0;
  logic [15:0] next_im;
  assign next_im = (wr_addr == '0) ? serial_q + 16'd1 : serial_q;

  always @(posedge clk) begin
    if (wr_en) begin
      mem_re[wr_bank][wr_addr] <= 16'(wr_addr);
      mem_im[wr_bank][wr_addr] <= next_im;
      serial_q <= next_im;
    end
    rd_re <= mem_re[rd_bank][rd_addr];
    rd_im <= mem_im[rd_bank][rd_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit dv, input bit rdy);
    @(negedge clk);
    din_valid = dv;
    out_ready = rdy;
    #1;
  endtask

  function automatic int brev(input int x);
    int r = 0;
    for (int i = 0; i < N; i++) if ((x & (1 << i)) != 0) r |= 1 << (N - 1 - i);
    return r;
  endfunction

  function automatic int any_out();
    return int'(|{fft_en, wr_en, wr_bank, wr_addr, rd_bank, rd_addr, out_valid, out_idx,
                  out_re, out_im, bank_full, frame_drop, frame_done});
  endfunction

`ifndef FFT_SCHED_PACE_EN
  typedef struct {
    bit rdy;
    bit v;
    int addr;
    int idx;
    int re;
  } vec_t;
  vec_t tbl[12];
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first_wr, first_addr, nwr, last_addr, ndrop, drop_at, nwr_a, nwr_c;
    int done_at, data_bad, exp_idx, k0, gap, found, adv_bad;

`ifndef FFT_SCHED_PACE_EN
    tbl[0]  = '{1'b1, 1'b1, 0,   0, 0};
    tbl[1]  = '{1'b1, 1'b0, 256, 1, 0};
    tbl[2]  = '{1'b1, 1'b1, 256, 1, 256};
    tbl[3]  = '{1'b1, 1'b0, 128, 2, 0};
    tbl[4]  = '{1'b1, 1'b1, 128, 2, 128};
    tbl[5]  = '{1'b1, 1'b0, 384, 3, 0};
    tbl[6]  = '{1'b1, 1'b1, 384, 3, 384};
    tbl[7]  = '{1'b0, 1'b0, 64,  4, 0};
    tbl[8]  = '{1'b0, 1'b1, 64,  4, 64};
    tbl[9]  = '{1'b0, 1'b1, 64,  4, 64};
    tbl[10] = '{1'b1, 1'b1, 64,  4, 64};
    tbl[11] = '{1'b1, 1'b0, 320, 5, 0};
`endif

    areset = 1'b1; din_valid = 1'b0; out_ready = 1'b0;
    cyc(0, 0);
    cyc(0, 0);
    chk("reset_outputs", any_out(), 0);
    chk("reset_bank_full", int'(bank_full), 0);

    // Priming and first frame into bank 0
    areset = 1'b0;
    first_wr = 0; first_addr = -1; nwr = 0; last_addr = -1;
    for (int v = 1; v <= 521; v++) begin
      cyc(1, 0);
      if (v == 1) chk("fft_en_follows_valid", int'(fft_en), 1);
      if (wr_en) begin
        nwr++;
        if (first_wr == 0) begin
          first_wr = v;
          first_addr = int'(wr_addr);
        end
        if (v == 521) last_addr = int'(wr_addr);
      end
    end
    chk("first_write_valid_no", first_wr, 10);
    chk("first_write_addr", first_addr, 0);
    chk("frame0_write_count", nwr, 512);
    chk("frame0_last_addr", last_addr, 511);
    cyc(0, 0);
    chk("bank_full_after_frame0", int'(bank_full), 1);
    chk("wr_bank_after_frame0", int'(wr_bank), 1);

    // Scan of bank 0 in bit-reversed order
    found = 0;
    for (int c = 0; c < 50; c++) begin
      cyc(0, 0);
      if (out_valid) begin
        found = 1;
        break;
      end
    end
    chk("scan0_first_valid_seen", found, 1);
    chk("scan0_first_idx", int'(out_idx), 0);
    chk("scan0_first_im", int'(out_im), 1);
    chk("scan0_rd_bank", int'(rd_bank), 0);

    k0 = 0;
    exp_idx = 0;
`ifndef FFT_SCHED_PACE_EN
    for (int k = 0; k < 12; k++) begin
      cyc(0, tbl[k].rdy);
      chk($sformatf("tbl%0d_valid", k), int'(out_valid), int'(tbl[k].v));
      chk($sformatf("tbl%0d_rd_addr", k), int'(rd_addr), tbl[k].addr);
      if (tbl[k].v) begin
        chk($sformatf("tbl%0d_idx", k), int'(out_idx), tbl[k].idx);
        chk($sformatf("tbl%0d_re", k), int'(out_re), tbl[k].re);
      end
    end
    k0 = 12;
    exp_idx = 5;
`endif
    done_at = -1; data_bad = 0;
    for (int k = k0; k < 5000; k++) begin
      cyc(0, 1);
      if (out_valid) begin
        if (int'(out_idx) != exp_idx || int'(out_re) != brev(int'(out_idx)) || out_im != 16'sd1)
          data_bad++;
        exp_idx++;
      end
      if (frame_done) begin
        done_at = k;
        break;
      end
    end
    chk("scan0_done_seen", int'(done_at >= 0), 1);
`ifndef FFT_SCHED_PACE_EN
    chk("scan0_done_cycle", done_at, 1024);
`endif
    chk("scan0_data_errors", data_bad, 0);
    chk("scan0_sample_count", exp_idx, 512);
    cyc(0, 0);
    chk("bank_full_after_scan0", int'(bank_full), 0);

    // Three frames with the consumer stalled: the third is dropped
    ndrop = 0; drop_at = 0; nwr_a = 0; nwr_c = 0;
    for (int v = 1; v <= 1536; v++) begin
      cyc(1, 0);
      if (frame_drop) begin
        ndrop++;
        drop_at = v;
      end
      if (wr_en) begin
        if (v <= 1024) nwr_a++;
        else nwr_c++;
      end
    end
    chk("drop_pulse_count", ndrop, 1);
    chk("drop_pulse_position", drop_at, 1025);
    chk("kept_frames_writes", nwr_a, 1024);
    chk("dropped_frame_writes", nwr_c, 0);
    cyc(0, 0);
    chk("bank_full_both", int'(bank_full), 3);
    chk("wr_bank_unchanged_by_drop", int'(wr_bank), 1);
    chk("reader_on_bank1", int'(rd_bank), 1);

    // Valid latency after entering the address phase
    cyc(0, 1);
    chk("scan1_first_valid", int'(out_valid), 1);
    chk("scan1_first_im", int'(out_im), 2);
    cyc(0, 0);
    chk("addr_phase_not_valid", int'(out_valid), 0);
    gap = -1;
    for (int g = 1; g <= 20; g++) begin
      cyc(0, 0);
      if (out_valid) begin
        gap = g;
        break;
      end
    end
    chk("valid_gap_after_addr_entry", gap, EXP_GAP);

    // Bring the bank 1 scan to its final sample, then release it as the next frame starts
    found = 0; adv_bad = 0;
    for (int c = 0; c < 4000; c++) begin
      cyc(0, 1);
      if (out_valid && out_idx == 9'd511) begin
        out_ready = 1'b0;
        found = 1;
        break;
      end
      if (out_valid && (int'(out_re) != brev(int'(out_idx)) || out_im != 16'sd2)) adv_bad++;
    end
    chk("scan1_reached_last", found, 1);
    chk("scan1_data_errors", adv_bad, 0);
    cyc(1, 1);
    chk("release_same_cycle_no_drop", int'(frame_drop), 0);
    chk("release_same_cycle_wr_en", int'(wr_en), 1);
    chk("release_same_cycle_wr_addr", int'(wr_addr), 0);
    chk("release_same_cycle_done", int'(frame_done), 1);
    cyc(1, 0);
    chk("bank_full_after_release", int'(bank_full), 1);

    // Reset in the middle of a scan and a frame write
    found = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      din_valid = (wr_addr != 9'd300);
      out_ready = (out_idx != 9'd100);
      #1;
      if (wr_addr == 9'd300 && out_valid && out_idx == 9'd100) begin
        found = 1;
        break;
      end
    end
    chk("mid_state_reached", found, 1);
    @(negedge clk);
    areset = 1'b1; din_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    areset = 1'b0;
    #1;
    chk("midreset_outputs", any_out(), 0);
    chk("midreset_bank_full", int'(bank_full), 0);
    first_wr = 0; first_addr = -1; ndrop = 0;
    for (int v = 1; v <= 20; v++) begin
      cyc(1, 0);
      if (frame_drop) ndrop++;
      if (wr_en && first_wr == 0) begin
        first_wr = v;
        first_addr = int'(wr_addr);
      end
    end
    chk("reprime_first_write", first_wr, 10);
    chk("reprime_first_addr", first_addr, 0);
    chk("reprime_no_drop", ndrop, 0);
    chk("reprime_reader_idle", int'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
